nes_pad_reader: RTL and testbench

Serial reader for one standard NES controller on the board GPIO header, feeding the CPU-side joypad register ($4016) inside `fpganes_clone`. It polls the pad at a fixed rate by driving latch and clock pulses, deserialises the 8 button bits, and holds the last complete sample. The block presents NES-compatible strobe/shift semantics to the CPU bus decoder so games read buttons exactly as on hardware.

---
 rtl/nes_pad_reader.sv | 183 ++++++++++++++++++
 tb/tb_nes_pad_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
// NES controller poller plus the CPU-visible $4016 strobe/shift register.
// Polls the pad once per POLL_CYC, deserialises eight buttons, and replays them to the CPU.
module nes_pad_reader #(
  parameter int LATCH_CYC = 600,
  parameter int HALF_CYC  = 300,
  parameter int POLL_CYC  = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       cpu_wr,
  input  logic       cpu_wdata,
  input  logic       cpu_rd,
  output logic       cpu_dout,
  output logic [7:0] buttons,
  output logic       frame_done
);

  localparam int PW    = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int TMAX  = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   poll_reg;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      data_reg, data_next;
  logic [7:0]      buttons_reg, buttons_next;
  logic            done_reg, done_next;
  logic            latch_reg, latch_next;
  logic            pclk_reg, pclk_next;
  logic [1:0]      sync_reg;
  logic            pressed;

  logic            strb_reg, strb_next;
  logic [7:0]      sr_reg, sr_next;
  logic            dout_reg, dout_next;

  // Synchroniser idles at 1 so a released pad reads as "not pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], pad_data};
    end
  end

  assign pressed = ~sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_reg <= '0;
    end else if (poll_reg == PW'(POLL_CYC - 1)) begin
      poll_reg <= '0;
    end else begin
      poll_reg <= poll_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      bit_reg     <= '0;
      data_reg    <= '0;
      buttons_reg <= '0;
      done_reg    <= 1'b0;
      latch_reg   <= 1'b0;
      pclk_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_reg     <= bit_next;
      data_reg    <= data_next;
      buttons_reg <= buttons_next;
      done_reg    <= done_next;
      latch_reg   <= latch_next;
      pclk_reg    <= pclk_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg + 1'b1;
    bit_next     = bit_reg;
    data_next    = data_reg;
    buttons_next = buttons_reg;
    done_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        if (poll_reg == '0) begin
          state_next = S_LATCH;
          bit_next   = 3'd0;
        end
      end
      S_LATCH: begin
        if (timer_reg == TW'(LATCH_CYC - 1)) begin
          data_next[0] = pressed;
          bit_next     = 3'd1;
          timer_next   = '0;
          state_next   = S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (timer_reg == TW'(HALF_CYC - 1)) begin
          timer_next = '0;
          state_next = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        // The pad shifted on the rising edge; sample late in the low phase.
        if (timer_reg == TW'(HALF_CYC - 1)) begin
          data_next[bit_reg] = pressed;
          timer_next         = '0;
          if (bit_reg == 3'd7) begin
            state_next = S_DONE;
          end else begin
            bit_next   = bit_reg + 3'd1;
            state_next = S_CLK_HI;
          end
        end
      end
      S_DONE: begin
        buttons_next = data_reg;
        done_next    = 1'b1;
        timer_next   = '0;
        state_next   = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
    latch_next = (state_next == S_LATCH);
    pclk_next  = (state_next == S_CLK_HI);
  end

  assign pad_latch  = latch_reg;
  assign pad_clk    = pclk_reg;
  assign buttons    = buttons_reg;
  assign frame_done = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_reg <= 1'b0;
      sr_reg   <= '0;
      dout_reg <= 1'b0;
    end else begin
      strb_reg <= strb_next;
      sr_reg   <= sr_next;
      dout_reg <= dout_next;
    end
  end

  // A read sees the pre-write strobe/shift state; a strobe-high write reloads at the same edge.
  always_comb begin
    strb_next = cpu_wr ? cpu_wdata : strb_reg;
    sr_next   = sr_reg;
    dout_next = dout_reg;
    if (cpu_rd) begin
      dout_next = sr_reg[0];
    end
    if (strb_next) begin
      sr_next = buttons_reg;
    end else if (cpu_rd && !strb_reg) begin
      sr_next = {1'b1, sr_reg[7:1]};
    end
  end

  assign cpu_dout = dout_reg;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Randomised bench for nes_pad_reader: a 4021-style pad model drives the serial line,
// and expected buttons / CPU read streams come from a per-frame behavioural model.
module tb_nes_pad_reader;

  localparam int LATCH_CYC = 4;
  localparam int HALF_CYC  = 2;
  localparam int POLL_CYC  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic       cpu_wr = 1'b0;
  logic       cpu_wdata = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       cpu_dout;
  logic [7:0] buttons;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  logic [7:0] pad_wire = 8'hFF;
  logic [3:0] pad_idx = 4'd0;
  logic [7:0] exp_btn = 8'h00;

  nes_pad_reader #(
    .LATCH_CYC(LATCH_CYC),
    .HALF_CYC (HALF_CYC),
    .POLL_CYC (POLL_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rd    (cpu_rd),
    .cpu_dout  (cpu_dout),
    .buttons   (buttons),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Pad: latch parks on button 0, each pad_clk rise advances one button; wire is active-low.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx <= 4'd0;
    else           pad_idx <= pad_idx + 4'd1;
  end
  assign pad_data = pad_idx[3] ? 1'b0 : pad_wire[pad_idx[2:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic v);
    cpu_wr = 1'b1;
    cpu_wdata = v;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(output logic d);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    d = cpu_dout;
  endtask

  task automatic cpu_read_write1(output logic d);
    cpu_rd = 1'b1;
    cpu_wr = 1'b1;
    cpu_wdata = 1'b1;
    tick();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    d = cpu_dout;
  endtask

  // Waits for frame_done; buttons must not move on any cycle without it.
  task automatic wait_frame(input string tag);
    logic [7:0] prev;
    bit moved;
    bit seen;
    prev = buttons;
    moved = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * POLL_CYC && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
      else if (buttons !== prev) moved = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_hold"}, moved, 1'b0);
  endtask

  task automatic wait_rises(input int n, input string tag);
    logic prev;
    int cnt;
    prev = pad_clk;
    cnt = 0;
    for (int i = 0; i < 4 * POLL_CYC && cnt < n; i++) begin
      tick();
      if (pad_clk && !prev) cnt++;
      prev = pad_clk;
    end
    check({tag, "_rises"}, cnt, n);
  endtask

  function automatic logic model_bit(input logic [7:0] b, input int j);
    return (j < 8) ? b[j] : 1'b1;
  endfunction

  task automatic cpu_sequence(input int n);
    logic d;
    cpu_write(1'b1);
    cpu_write(1'b0);
    for (int j = 0; j < n; j++) begin
      cpu_read(d);
      check($sformatf("rd%0d", j), d, model_bit(exp_btn, j));
    end
    cpu_read_write1(d);
    check("rdwr_pre", d, model_bit(exp_btn, n));
    cpu_read(d);
    check("rdwr_post", d, exp_btn[0]);
    cpu_write(1'b0);
    $display("cpu seq: buttons=%02h reads=%0d", exp_btn, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d;
    logic [7:0] old_p, new_p, mask;
    int k;

    // Reset state.
    pad_wire = 8'b10110110;
    repeat (3) tick();
    check("rst_outs", {pad_latch, pad_clk, cpu_dout, frame_done}, 4'b0000);
    check("rst_buttons", buttons, 8'h00);

    // Frame waveform for two poll periods from release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * POLL_CYC; c++) begin
      int m;
      logic el, ec, ed;
      tick();
      m = c % POLL_CYC;
      el = (m < LATCH_CYC);
      ec = (m >= LATCH_CYC) && (m < LATCH_CYC + 14 * HALF_CYC) &&
           (((m - LATCH_CYC) % (2 * HALF_CYC)) < HALF_CYC);
      ed = (m == LATCH_CYC + 14 * HALF_CYC + 1);
      check($sformatf("wave_c%0d", c), {pad_latch, pad_clk, frame_done}, {el, ec, ed});
      if (c == LATCH_CYC + 14 * HALF_CYC + 1) check("first_buttons", buttons, 8'h49);
    end
    exp_btn = ~pad_wire;
    $display("frame: wire=%02h buttons=%02h", pad_wire, buttons);

    // CPU protocol on 0x49: ten reads after strobe pulse.
    cpu_write(1'b1);
    cpu_write(1'b0);
    for (int j = 0; j < 10; j++) begin
      cpu_read(d);
      check($sformatf("seq49_rd%0d", j), d, model_bit(exp_btn, j));
    end
    repeat (3) tick();
    check("dout_hold", cpu_dout, 1'b1);
    cpu_write(1'b1);
    for (int j = 0; j < 4; j++) begin
      cpu_read(d);
      check("strb_high_rd", d, exp_btn[0]);
    end
    cpu_write(1'b0);
    cpu_sequence(3);

    // Random pad patterns, each followed by a random CPU read sequence.
    for (int f = 0; f < 8; f++) begin
      wait_frame("sync");
      pad_wire = 8'($urandom);
      wait_frame("rand");
      exp_btn = ~pad_wire;
      check("rand_buttons", buttons, exp_btn);
      $display("frame: wire=%02h buttons=%02h", pad_wire, buttons);
      cpu_sequence($urandom_range(0, 9));
    end

    // Reset during the third pad clock high phase.
    wait_frame("pre_rst");
    wait_rises(3, "rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pad", {pad_latch, pad_clk}, 2'b00);
    check("async_rst_buttons", buttons, 8'h00);
    check("async_rst_dout", {cpu_dout, frame_done}, 2'b00);
    pad_wire = 8'($urandom);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      check($sformatf("rst_wave_c%0d", c), {pad_latch, frame_done},
            {c < LATCH_CYC, c == LATCH_CYC + 14 * HALF_CYC + 1});
    end
    exp_btn = ~pad_wire;
    check("post_rst_buttons", buttons, exp_btn);
    $display("frame after reset: wire=%02h buttons=%02h", pad_wire, buttons);

    // Mid-frame change: nothing pressed -> all pressed at the 4th shift clock.
    wait_frame("mix_sync");
    pad_wire = 8'hFF;
    wait_frame("mix_prev");
    exp_btn = 8'h00;
    check("mix_prev_buttons", buttons, exp_btn);
    wait_rises(4, "mix");
    check("mix_hold", buttons, exp_btn);
    pad_wire = 8'h00;
    wait_frame("mix");
    check("mix_buttons", buttons, 8'hF0);
    wait_frame("mix_next");
    check("mix_next_buttons", buttons, 8'hFF);

    // Random mid-frame changes at a random shift clock.
    for (int f = 0; f < 6; f++) begin
      old_p = 8'($urandom);
      new_p = 8'($urandom);
      k = $urandom_range(1, 7);
      mask = 8'((1 << k) - 1);
      pad_wire = old_p;
      wait_rises(k, "rmix");
      pad_wire = new_p;
      wait_frame("rmix");
      exp_btn = (~old_p & mask) | (~new_p & ~mask);
      check("rmix_buttons", buttons, exp_btn);
      $display("mixed frame: old=%02h new=%02h k=%0d buttons=%02h", old_p, new_p, k, buttons);
      wait_frame("rmix_settle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
